vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
// - Parametrised horizontal+vertical raster timing generator for the graphic controller.
// - Replaces the separate line and frame counters with a single block.
// - Emits H/V sync with configurable polarity, an active-video flag, pixel coordinates,
//   and line/frame strobes, all advanced by a pixel-clock enable.
// - Feeds the pixel fetch path and the DAC/VGA pins.
// PARAMETERS
// - H_VISIBLE   640  visible pixels per line
// - H_FRONT     16   horizontal front porch, in pixels
// - H_SYNC      96   horizontal sync width, in pixels
// - H_BACK      48   horizontal back porch, in pixels; must be >= 1
// - V_VISIBLE   480  visible lines per frame
// - V_FRONT     10   vertical front porch, in lines
// - V_SYNC      2    vertical sync width, in lines
// - V_BACK      33   vertical back porch, in lines; must be >= 1
// - H_SYNC_POL  0    asserted level of H_SYNC (0 = active-low)
// - V_SYNC_POL  0    asserted level of V_SYNC
// - CNT_W       11   counter width; elaboration error if 2**CNT_W < H_TOTAL or < V_TOTAL
// PORTS
// - CLOCK        in   1      system clock; all logic on posedge
// - RESET        in   1      asynchronous, active-high reset
// - ENABLE       in   1      pixel tick; all state advances only when ENABLE=1
// - H_COUNT      out  CNT_W  current column, 0..H_TOTAL-1
// - V_COUNT      out  CNT_W  current line, 0..V_TOTAL-1
// - H_SYNC       out  1      registered horizontal sync
// - V_SYNC       out  1      registered vertical sync
// - ACTIVE       out  1      1 when H_COUNT<H_VISIBLE and V_COUNT<V_VISIBLE
// - PIXEL_X      out  CNT_W  H_COUNT while ACTIVE, else 0
// - PIXEL_Y      out  CNT_W  V_COUNT while ACTIVE, else 0
// - LINE_END     out  1      1 while H_COUNT==H_TOTAL-1
// - FRAME_START  out  1      1 while H_COUNT==0 and V_COUNT==0
// BEHAVIOUR
// - Totals: H_TOTAL = sum of the H_* periods (800); V_TOTAL = sum of the V_* periods (525).
//   Counters wrap at TOTAL-1 -> 0; no count equals TOTAL.
// - Reset: counters go to (H_TOTAL-1, V_TOTAL-1).
//   - Reset values: H_SYNC=~H_SYNC_POL, V_SYNC=~V_SYNC_POL, ACTIVE=0, PIXEL_X=PIXEL_Y=0,
//     LINE_END=1, FRAME_START=0.
//   - These are exactly the decoded values for that position.
//   - The first ENABLE after release moves to (0,0) with FRAME_START=1.
// - Reset mid-frame acts immediately (async) and takes the same values. No partial-frame recovery.
// - Advance on ENABLE=1:
//   - H_COUNT increments.
//   - At H_TOTAL-1, H_COUNT -> 0 and V_COUNT increments (V wraps V_TOTAL-1 -> 0 in the same cycle).
//   - ENABLE=0 holds every register and output unchanged. Strobes stay high if they were high.
// - All outputs are registered and decoded from next-state counts. They are cycle-aligned with
//   H_COUNT/V_COUNT: zero skew and no combinational glitches on the pins.
// - H_SYNC is asserted for H_COUNT in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]
//   (656..751 with defaults).
// - V_SYNC is asserted for V_COUNT in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]
//   (490..491), over whole lines.
// - V_SYNC edges coincide with H_COUNT==0.
// - Simultaneous H and V wrap: the line and frame wrap together.
//   - LINE_END is high at (799,524).
//   - FRAME_START is high on the next enabled cycle.
// - Arithmetic: unsigned, CNT_W bits, compare against localparam boundaries only.
//   No run-time configuration.
// STRUCTURE
// - Package vga_timing_pkg:
//   - typedef struct vga_axis_t {visible, front, sync, back};
//   - localparams VGA_640x480_60 and VGA_800x600_60;
//   - function axis_total().
// - Sub-module vga_axis_counter (params VISIBLE/FRONT/SYNC/BACK/POL/CNT_W; ports CLOCK, RESET,
//   STEP, count, sync, visible, wrap) is instantiated twice:
//   - horizontal: STEP=ENABLE;
//   - vertical: STEP=ENABLE & h_wrap.
//   The top level combines the two and registers ACTIVE, PIXEL_X/Y and the strobes.
// TESTING
// - Reset asserted, then released, ENABLE=1 -> first edge: H_COUNT=0, V_COUNT=0,
//   FRAME_START=1, ACTIVE=1.
// - Free run, defaults -> H_SYNC low for exactly 96 ticks starting at H_COUNT=656.
//   LINE_END period is 800 ticks. FRAME_START period is 420000 ticks.
// - Frame scan -> V_SYNC low exactly on lines 490,491, changing only at H_COUNT=0.
//   ACTIVE count per frame = 307200.
// - ENABLE toggled 1/0 each cycle -> sequence identical to the free run but stretched 2x.
//   Outputs hold during ENABLE=0.
// - RESET pulsed at (H=300, V=200) -> outputs hit reset values asynchronously.
//   Restart yields FRAME_START on the first ENABLE.
// - H_SYNC_POL=1, V_SYNC_POL=1, 800x600 params -> syncs active-high.
//   H_TOTAL=1056, V_TOTAL=628.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster timing types, standard mode tables and helpers for the VGA
// timing generator.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned visible;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_mode_t;

  localparam vga_mode_t VGA_640x480_60 = '{h: '{640, 16, 96, 48}, v: '{480, 10, 2, 33}};
  localparam vga_mode_t VGA_800x600_60 = '{h: '{800, 40, 128, 88}, v: '{600, 1, 4, 23}};

  function automatic int unsigned axis_total(vga_axis_t a);
    return a.visible + a.front + a.sync + a.back;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: pixel-tick enable in, counters/syncs/strobes out.
interface vga_timing_gen_if #(
  parameter int unsigned CNT_W = 11
);
  logic             ENABLE;
  logic [CNT_W-1:0] H_COUNT;
  logic [CNT_W-1:0] V_COUNT;
  logic             H_SYNC;
  logic             V_SYNC;
  logic             ACTIVE;
  logic [CNT_W-1:0] PIXEL_X;
  logic [CNT_W-1:0] PIXEL_Y;
  logic             LINE_END;
  logic             FRAME_START;

  modport master (
    input  ENABLE,
    output H_COUNT, V_COUNT, H_SYNC, V_SYNC, ACTIVE,
           PIXEL_X, PIXEL_Y, LINE_END, FRAME_START
  );

  modport slave (
    output ENABLE,
    input  H_COUNT, V_COUNT, H_SYNC, V_SYNC, ACTIVE,
           PIXEL_X, PIXEL_Y, LINE_END, FRAME_START
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with sync/visible/wrap flags
// registered from the next-state count so they stay aligned with it.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned VISIBLE = 640,
  parameter int unsigned FRONT   = 16,
  parameter int unsigned SYNC    = 96,
  parameter int unsigned BACK    = 48,
  parameter bit          POL     = 1'b0,
  parameter int unsigned CNT_W   = 11
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             STEP,
  output logic [CNT_W-1:0] count,
  output logic             sync,
  output logic             visible,
  output logic             wrap
);
  localparam vga_axis_t        AXIS     = '{visible: VISIBLE, front: FRONT, sync: SYNC, back: BACK};
  localparam int unsigned      TOTAL    = axis_total(AXIS);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS_END  = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(VISIBLE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(VISIBLE + FRONT + SYNC);

  // The reset position (LAST) must sit in the back porch so its decode is idle.
  if (BACK < 1) begin : g_chk_back
    $error("vga_axis_counter: BACK must be >= 1");
  end
  if (longint'(TOTAL) > (longint'(1) << CNT_W)) begin : g_chk_width
    $error("vga_axis_counter: CNT_W too small for axis total");
  end

  logic [CNT_W-1:0] count_nxt;
  assign count_nxt = (count == LAST) ? '0 : count + 1'b1;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      count   <= LAST;
      sync    <= ~POL;
      visible <= 1'b0;
      wrap    <= 1'b1;
    end else if (STEP) begin
      count   <= count_nxt;
      sync    <= (count_nxt >= SYNC_BEG && count_nxt < SYNC_END) ? POL : ~POL;
      visible <= (count_nxt < VIS_END);
      wrap    <= (count_nxt == LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Horizontal+vertical raster timing generator: two axis counters plus
// registered active-video, pixel coordinate and frame-start decode.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = VGA_640x480_60.h.visible,
  parameter int unsigned H_FRONT    = VGA_640x480_60.h.front,
  parameter int unsigned H_SYNC     = VGA_640x480_60.h.sync,
  parameter int unsigned H_BACK     = VGA_640x480_60.h.back,
  parameter int unsigned V_VISIBLE  = VGA_640x480_60.v.visible,
  parameter int unsigned V_FRONT    = VGA_640x480_60.v.front,
  parameter int unsigned V_SYNC     = VGA_640x480_60.v.sync,
  parameter int unsigned V_BACK     = VGA_640x480_60.v.back,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CNT_W      = 11
) (
  input  logic             CLOCK,
  input  logic             RESET,
  vga_timing_gen_if.master bus
);
  localparam logic [CNT_W-1:0] H_VIS_LAST = CNT_W'(H_VISIBLE - 1);
  localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_VISIBLE - 1);

  logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic             h_vis, v_vis, h_wrap, v_wrap;
  logic             h_vis_nxt, v_vis_nxt, act_nxt;
  logic             active_q, fstart_q;
  logic [CNT_W-1:0] px_q, py_q;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .POL(H_SYNC_POL), .CNT_W(CNT_W)
  ) u_h (
    .CLOCK(CLOCK), .RESET(RESET), .STEP(bus.ENABLE),
    .count(h_cnt), .sync(bus.H_SYNC), .visible(h_vis), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .POL(V_SYNC_POL), .CNT_W(CNT_W)
  ) u_v (
    .CLOCK(CLOCK), .RESET(RESET), .STEP(bus.ENABLE & h_wrap),
    .count(v_cnt), .sync(bus.V_SYNC), .visible(v_vis), .wrap(v_wrap)
  );

  // Next-state visibility is derived incrementally from the current flags,
  // so the active decode lands on the same edge as the counters.
  always_comb begin
    h_nxt     = h_wrap ? '0 : h_cnt + 1'b1;
    h_vis_nxt = h_wrap | (h_vis & (h_cnt != H_VIS_LAST));
    v_nxt     = v_cnt;
    v_vis_nxt = v_vis;
    if (h_wrap) begin
      v_nxt     = v_wrap ? '0 : v_cnt + 1'b1;
      v_vis_nxt = v_wrap | (v_vis & (v_cnt != V_VIS_LAST));
    end
    act_nxt = h_vis_nxt & v_vis_nxt;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      active_q <= 1'b0;
      px_q     <= '0;
      py_q     <= '0;
      fstart_q <= 1'b0;
    end else if (bus.ENABLE) begin
      active_q <= act_nxt;
      px_q     <= act_nxt ? h_nxt : '0;
      py_q     <= act_nxt ? v_nxt : '0;
      fstart_q <= h_wrap & v_wrap;
    end
  end

  assign bus.H_COUNT     = h_cnt;
  assign bus.V_COUNT     = v_cnt;
  assign bus.ACTIVE      = active_q;
  assign bus.PIXEL_X     = px_q;
  assign bus.PIXEL_Y     = py_q;
  assign bus.LINE_END    = h_wrap;
  assign bus.FRAME_START = fstart_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a tiny 15x8 raster checked cycle-by-cycle, plus default
// 640x480 and active-high 800x600 instances checked over whole lines.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  logic en    = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   mh    = 0;
  int   mv    = 0;

  always #5 CLOCK = ~CLOCK;

  vga_timing_gen_if #(.CNT_W(4))  b1();
  vga_timing_gen_if #(.CNT_W(11)) b2();
  vga_timing_gen_if #(.CNT_W(11)) b3();
  assign b1.ENABLE = en;
  assign b2.ENABLE = en;
  assign b3.ENABLE = en;

  // Small raster: H 8+2+3+2=15 (sync cols 10..12), V 4+1+2+1=8 (sync lines 5..6).
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CNT_W(4)
  ) u_small (.CLOCK(CLOCK), .RESET(RESET), .bus(b1));

  vga_timing_gen #(
    .H_VISIBLE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
    .V_VISIBLE(600), .V_FRONT(1), .V_SYNC(4), .V_BACK(23),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(11)
  ) u_svga (.CLOCK(CLOCK), .RESET(RESET), .bus(b2));

  vga_timing_gen u_vga (.CLOCK(CLOCK), .RESET(RESET), .bus(b3));

  typedef struct packed {
    logic [3:0] h, v;
    logic       hs, vs, act;
    logic [3:0] px, py;
    logic       le, fs;
  } obs_t;

  function automatic obs_t model(int h, int v);
    obs_t e;
    e.h   = 4'(h);
    e.v   = 4'(v);
    e.hs  = !(h >= 10 && h <= 12);
    e.vs  = !(v >= 5 && v <= 6);
    e.act = (h < 8) && (v < 4);
    e.px  = e.act ? 4'(h) : 4'd0;
    e.py  = e.act ? 4'(v) : 4'd0;
    e.le  = (h == 14);
    e.fs  = (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.h = b1.H_COUNT;  o.v = b1.V_COUNT;
    o.hs = b1.H_SYNC;  o.vs = b1.V_SYNC;  o.act = b1.ACTIVE;
    o.px = b1.PIXEL_X; o.py = b1.PIXEL_Y;
    o.le = b1.LINE_END; o.fs = b1.FRAME_START;
    return o;
  endfunction

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic adv();
    if (mh == 14) begin
      mh = 0;
      mv = (mv == 7) ? 0 : mv + 1;
    end else begin
      mh++;
    end
  endtask

  task automatic test_reset();
    obs_t got, exp;
    RESET = 1'b1; en = 1'b0;
    repeat (3) tick();
    got = sample(); exp = model(14, 7);
    total++;
    if (got !== exp) begin bad++; $display("FAIL reset_state got=%h exp=%h", got, exp); end
    en = 1'b1;
    tick();
    got = sample();
    total++;
    if (got !== exp) begin bad++; $display("FAIL reset_hold_en got=%h exp=%h", got, exp); end
    RESET = 1'b0;
    tick();
    mh = 0; mv = 0;
    got = sample(); exp = model(0, 0);
    total++;
    if (got !== exp) begin bad++; $display("FAIL first_enable got=%h exp=%h", got, exp); end
  endtask

  task automatic test_free_run();
    obs_t got, exp;
    int hs_first = -1, hs_cnt = 0, le_prev = -1, le_per = -1;
    int fs_prev = -1, fs_per = -1, act_cnt = 0, vs_low = 0, vs_edge_bad = 0;
    logic vs_prev = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 240; i++) begin
      got = sample(); exp = model(mh, mv);
      total++;
      if (got !== exp) begin
        bad++;
        if (bad <= 20) $display("FAIL free_run i=%0d got=%h exp=%h", i, got, exp);
      end
      if (i < 15 && !got.hs) begin if (hs_first < 0) hs_first = i; hs_cnt++; end
      if (got.le) begin if (le_prev >= 0 && le_per < 0) le_per = i - le_prev; le_prev = i; end
      if (got.fs) begin if (fs_prev >= 0 && fs_per < 0) fs_per = i - fs_prev; fs_prev = i; end
      if (i < 120 && got.act) act_cnt++;
      if (i < 120 && !got.vs) vs_low++;
      if (i > 0 && got.vs != vs_prev && got.h != 4'd0) vs_edge_bad++;
      vs_prev = got.vs;
      tick(); adv();
    end
    total++; if (hs_first != 10) begin bad++; $display("FAIL hsync_start got=%0d exp=10", hs_first); end
    total++; if (hs_cnt != 3)    begin bad++; $display("FAIL hsync_width got=%0d exp=3", hs_cnt); end
    total++; if (le_per != 15)   begin bad++; $display("FAIL line_end_period got=%0d exp=15", le_per); end
    total++; if (fs_per != 120)  begin bad++; $display("FAIL frame_period got=%0d exp=120", fs_per); end
    total++; if (act_cnt != 32)  begin bad++; $display("FAIL active_count got=%0d exp=32", act_cnt); end
    total++; if (vs_low != 30)   begin bad++; $display("FAIL vsync_ticks got=%0d exp=30", vs_low); end
    total++; if (vs_edge_bad != 0) begin bad++; $display("FAIL vsync_edge_at_h0 got=%0d exp=0", vs_edge_bad); end
  endtask

  task automatic test_enable_toggle();
    obs_t got, exp;
    for (int i = 0; i < 60; i++) begin
      en = (i % 2 == 0);
      tick();
      if (en) adv();
      got = sample(); exp = model(mh, mv);
      total++;
      if (got !== exp) begin
        bad++;
        if (bad <= 40) $display("FAIL enable_toggle i=%0d got=%h exp=%h", i, got, exp);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    en = 1'b1;
    for (int k = 0; k < 200 && !(mh == 5 && mv == 2); k++) begin tick(); adv(); end
    total++;
    if (!(b1.H_COUNT == 4'd5 && b1.V_COUNT == 4'd2)) begin
      bad++; $display("FAIL reach_mid got=%0d,%0d exp=5,2", b1.H_COUNT, b1.V_COUNT);
    end
    #3 RESET = 1'b1;
    #1;
    got = sample(); exp = model(14, 7);
    total++;
    if (got !== exp) begin bad++; $display("FAIL async_reset got=%h exp=%h", got, exp); end
    tick();
    RESET = 1'b0;
    tick();
    mh = 0; mv = 0;
    got = sample(); exp = model(0, 0);
    total++;
    if (got !== exp) begin bad++; $display("FAIL restart_fs got=%h exp=%h", got, exp); end
  endtask

  task automatic test_wide_lines();
    int s_first = -1, s_cnt = 0, s_le_prev = -1, s_le_per = -1, s_vs_bad = 0;
    int d_first = -1, d_cnt = 0, d_le_prev = -1, d_le_per = -1, d_vs_bad = 0;
    RESET = 1'b1; en = 1'b1;
    tick(); tick();
    total++;
    if (!(b2.H_COUNT == 11'd1055 && b2.V_COUNT == 11'd627 && b2.H_SYNC == 1'b0 &&
          b2.V_SYNC == 1'b0 && b2.LINE_END == 1'b1)) begin
      bad++; $display("FAIL svga_reset got h=%0d v=%0d hs=%b vs=%b exp h=1055 v=627 hs=0 vs=0",
                      b2.H_COUNT, b2.V_COUNT, b2.H_SYNC, b2.V_SYNC);
    end
    total++;
    if (!(b3.H_COUNT == 11'd799 && b3.V_COUNT == 11'd524 && b3.H_SYNC == 1'b1 && b3.V_SYNC == 1'b1)) begin
      bad++; $display("FAIL vga_reset got h=%0d v=%0d hs=%b vs=%b exp h=799 v=524 hs=1 vs=1",
                      b3.H_COUNT, b3.V_COUNT, b3.H_SYNC, b3.V_SYNC);
    end
    RESET = 1'b0;
    for (int i = 0; i < 2114; i++) begin
      tick();
      if (i < 1056 && b2.H_SYNC) begin if (s_first < 0) s_first = i; s_cnt++; end
      if (b2.LINE_END) begin if (s_le_prev >= 0 && s_le_per < 0) s_le_per = i - s_le_prev; s_le_prev = i; end
      if (b2.V_SYNC !== 1'b0) s_vs_bad++;
      if (i < 800 && !b3.H_SYNC) begin if (d_first < 0) d_first = i; d_cnt++; end
      if (b3.LINE_END) begin if (d_le_prev >= 0 && d_le_per < 0) d_le_per = i - d_le_prev; d_le_prev = i; end
      if (b3.V_SYNC !== 1'b1) d_vs_bad++;
      if (i == 100) begin
        total++;
        if (!(b3.ACTIVE && b3.PIXEL_X == 11'd100 && b3.PIXEL_Y == 11'd0)) begin
          bad++; $display("FAIL vga_pixel_100 got act=%b x=%0d exp act=1 x=100", b3.ACTIVE, b3.PIXEL_X);
        end
      end
      if (i == 700) begin
        total++;
        if (!(!b3.ACTIVE && b3.PIXEL_X == 11'd0)) begin
          bad++; $display("FAIL vga_blank_700 got act=%b x=%0d exp act=0 x=0", b3.ACTIVE, b3.PIXEL_X);
        end
      end
    end
    total++; if (s_first != 840)  begin bad++; $display("FAIL svga_hsync_start got=%0d exp=840", s_first); end
    total++; if (s_cnt != 128)    begin bad++; $display("FAIL svga_hsync_width got=%0d exp=128", s_cnt); end
    total++; if (s_le_per != 1056) begin bad++; $display("FAIL svga_line_period got=%0d exp=1056", s_le_per); end
    total++; if (s_vs_bad != 0)   begin bad++; $display("FAIL svga_vsync_idle got=%0d exp=0", s_vs_bad); end
    total++;
    if (!(b2.H_COUNT == 11'd1 && b2.V_COUNT == 11'd2)) begin
      bad++; $display("FAIL svga_pos got=%0d,%0d exp=1,2", b2.H_COUNT, b2.V_COUNT);
    end
    total++; if (d_first != 656)  begin bad++; $display("FAIL vga_hsync_start got=%0d exp=656", d_first); end
    total++; if (d_cnt != 96)     begin bad++; $display("FAIL vga_hsync_width got=%0d exp=96", d_cnt); end
    total++; if (d_le_per != 800) begin bad++; $display("FAIL vga_line_period got=%0d exp=800", d_le_per); end
    total++; if (d_vs_bad != 0)   begin bad++; $display("FAIL vga_vsync_idle got=%0d exp=0", d_vs_bad); end
    total++;
    if (!(b3.H_COUNT == 11'd513 && b3.V_COUNT == 11'd2)) begin
      bad++; $display("FAIL vga_pos got=%0d,%0d exp=513,2", b3.H_COUNT, b3.V_COUNT);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_enable_toggle();
    test_reset_mid();
    test_wide_lines();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
